// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: shares one cacheline adaptor port between an I-cache and a D-cache.
// One transaction at a time; the grant is held until the adaptor responds, and every
// transaction is followed by exactly one IDLE arbitration cycle.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, simultaneous requests
// alternate between the two sides. When it is not defined, D-cache always wins a tie.
module cacheline_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,

    // I-cache side
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    // D-cache side
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    // Cacheline adaptor side
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Operation kind captured when the grant is issued. Holding it means the
    // transaction finishes even if the requester drops read/write mid-flight.
    logic   r_op_write;

    logic   w_i_req;
    logic   w_d_req;
    logic   w_any_req;
    logic   w_pick_d;
    logic   w_grant_write;

    assign w_i_req   = i_read | i_write;
    assign w_d_req   = d_read | d_write;
    assign w_any_req = w_i_req | w_d_req;

`ifdef ARB_ROUND_ROBIN_EN
    // Last-served side: 1 = D was served last. It resets to 0 so the first tie goes to D.
    logic r_last_d;

    // A tie goes to the side that was not served last. A lone requester always wins.
    assign w_pick_d = (w_i_req && w_d_req) ? ~r_last_d : w_d_req;

    // Record the winner every time a grant is issued from IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_d <= 1'b0;
        end else if (r_state == IDLE && w_any_req) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    // Fixed priority: D wins whenever it is requesting.
    assign w_pick_d = w_d_req;
`endif

    // Write takes precedence when a requester raises read and write together.
    assign w_grant_write = w_pick_d ? d_write : i_write;

    // State register and captured operation kind. Reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_op_write <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_any_req) begin
                r_op_write <= w_grant_write;
            end
        end
    end

    // Next-state logic. A grant is left only on mem_resp. mem_resp seen in IDLE is ignored.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_next = w_pick_d ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I: begin
                if (mem_resp) begin
                    w_state_next = IDLE;
                end
            end
            GRANT_D: begin
                if (mem_resp) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output muxing. Address and write data follow the granted side combinationally.
    // Read and write strobes come from the captured operation kind.
    always_comb begin
        mem_address = d_address;
        mem_wdata   = d_wdata;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        case (r_state)
            GRANT_I: begin
                mem_address = i_address;
                mem_wdata   = i_wdata;
                mem_write   = r_op_write;
                mem_read    = ~r_op_write;
                i_resp      = mem_resp;
            end
            GRANT_D: begin
                mem_address = d_address;
                mem_wdata   = d_wdata;
                mem_write   = r_op_write;
                mem_read    = ~r_op_write;
                d_resp      = mem_resp;
            end
            default: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        endcase
    end

    // Read data is broadcast unmodified. Each requester qualifies it with its own resp.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench for cacheline_arbiter: directed tasks push each expected response.
// A negedge monitor pops an entry and compares it whenever i_resp or d_resp is seen.
module tb_cacheline_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              reset_n;
    logic [ADDR_W-1:0] i_address, d_address, mem_address;
    logic              i_read, i_write, d_read, d_write;
    logic [LINE_W-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic              i_resp, d_resp, mem_read, mem_write, mem_resp;

    cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_address  (i_address),
        .i_read     (i_read),
        .i_write    (i_write),
        .i_wdata    (i_wdata),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_address  (d_address),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit                is_d;
        logic [LINE_W-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_item;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (i_resp === 1'b1 || d_resp === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b expected none", i_resp, d_resp);
            end else begin
                mon_item = sb.pop_front();
                chk("resp_i", {255'd0, i_resp}, {255'd0, ~mon_item.is_d});
                chk("resp_d", {255'd0, d_resp}, {255'd0, mon_item.is_d});
                chk("rdata", mon_item.is_d ? d_rdata : i_rdata, mon_item.rdata);
                $display("resp: side=%s rdata=%0h", mon_item.is_d ? "D" : "I", mon_item.rdata);
            end
        end
    end

    // Wait for a grant with a bounded budget. Check the strobes, address and write data.
    // Then answer after lat cycles. drop releases the served side's request afterwards.
    task automatic serve(input bit exp_d, input bit exp_w, input logic [ADDR_W-1:0] exp_addr,
                         input logic [LINE_W-1:0] exp_wdata, input int lat,
                         input logic [LINE_W-1:0] rdata, input bit drop, output int waited);
        exp_t e;
        waited = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            waited++;
            if (mem_read === 1'b1 || mem_write === 1'b1) break;
        end
        chk("grant_seen", {255'd0, (mem_read | mem_write)}, {255'd0, 1'b1});
        chk("mem_write", {255'd0, mem_write}, {255'd0, exp_w});
        chk("mem_read", {255'd0, mem_read}, {255'd0, ~exp_w});
        chk("mem_address", {224'd0, mem_address}, {224'd0, exp_addr});
        if (exp_w) chk("mem_wdata", mem_wdata, exp_wdata);
        $display("grant: side=%s write=%0b addr=%h", exp_d ? "D" : "I", exp_w, exp_addr);
        repeat (lat) @(posedge clk);
        #1;
        mem_rdata = rdata;
        mem_resp  = 1'b1;
        e.is_d  = exp_d;
        e.rdata = rdata;
        sb.push_back(e);
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
        if (drop) begin
            if (exp_d) begin d_read = 1'b0; d_write = 1'b0; end
            else       begin i_read = 1'b0; i_write = 1'b0; end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    int  w;
    bit  seq_d[4];
    logic [LINE_W-1:0] pat_a5, pat_5a, pat_w1, pat_w2;

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_5a = {32{8'h5A}};
        pat_w1 = {16{16'hBEEF}};
        pat_w2 = {8{32'h1234_5678}};
        reset_n = 1'b0;
        i_address = '0; i_read = 0; i_write = 0; i_wdata = '0;
        d_address = '0; d_read = 0; d_write = 0; d_wdata = '0;
        mem_rdata = '0; mem_resp = 0;

        // Reset state
        #12;
        chk("rst_mem_read", {255'd0, mem_read}, 256'd0);
        chk("rst_mem_write", {255'd0, mem_write}, 256'd0);
        chk("rst_resp", {254'd0, i_resp, d_resp}, 256'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // D read, the adaptor answers 4 cycles after the grant
        @(posedge clk);
        #1 d_address = 32'h0000_1040; d_read = 1'b1;
        @(negedge clk);
        chk("idle_before_grant", {255'd0, mem_read}, 256'd0);
        serve(1'b1, 1'b0, 32'h0000_1040, '0, 4, pat_a5, 1'b1, w);
        chk("grant_latency", w, 1);
        @(negedge clk);
        chk("idle_after_d", {255'd0, mem_read}, 256'd0);

        // Simultaneous I read and D write: D goes first, then one IDLE cycle, then I
        pulse_reset();
        @(posedge clk);
        #1 i_address = 32'h0000_2000; i_read = 1'b1;
        d_address = 32'h0000_3000; d_write = 1'b1; d_wdata = pat_w1;
        serve(1'b1, 1'b1, 32'h0000_3000, pat_w1, 2, '0, 1'b1, w);
        serve(1'b0, 1'b0, 32'h0000_2000, '0, 1, pat_5a, 1'b1, w);
        chk("one_idle_gap", w, 2);

        // Both sides request continuously for four transactions
        pulse_reset();
        @(posedge clk);
        #1 i_address = 32'h0000_2100; i_read = 1'b1;
        d_address = 32'h0000_3100; d_read = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        seq_d[0] = 1; seq_d[1] = 0; seq_d[2] = 1; seq_d[3] = 0;
`else
        seq_d[0] = 1; seq_d[1] = 1; seq_d[2] = 1; seq_d[3] = 1;
`endif
        for (int t = 0; t < 4; t++) begin
            serve(seq_d[t], 1'b0, seq_d[t] ? 32'h0000_3100 : 32'h0000_2100, '0, 1,
                  {8{t[31:0]}}, 1'b0, w);
        end
        i_read = 1'b0; d_read = 1'b0;
        repeat (2) @(posedge clk);

        // read and write together: only mem_write is driven
        @(posedge clk);
        #1 d_address = 32'h0000_4000; d_read = 1'b1; d_write = 1'b1; d_wdata = pat_w2;
        serve(1'b1, 1'b1, 32'h0000_4000, pat_w2, 1, '0, 1'b1, w);

        // Reset during GRANT_I abandons the transaction
        @(posedge clk);
        #1 i_address = 32'h0000_5000; i_read = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_read === 1'b1) break;
        end
        chk("rst_mid_granted", {255'd0, mem_read}, {255'd0, 1'b1});
        #1 reset_n = 1'b0; i_read = 1'b0;
        #1;
        chk("rst_mid_mem_read", {255'd0, mem_read}, 256'd0);
        chk("rst_mid_i_resp", {255'd0, i_resp}, 256'd0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_idle", {254'd0, mem_read, mem_write}, 256'd0);
        $display("reset: mid-transaction abandon");

        // mem_resp while IDLE is ignored
        @(posedge clk);
        #1 mem_resp = 1'b1; mem_rdata = pat_a5;
        @(negedge clk);
        chk("stray_resp", {254'd0, i_resp, d_resp}, 256'd0);
        @(posedge clk);
        #1 mem_resp = 1'b0;
        @(negedge clk);
        chk("stray_state", {254'd0, mem_read, mem_write}, 256'd0);
        $display("stray: mem_resp in IDLE");

        // d_read dropped two cycles after the grant: the grant is still held until mem_resp
        @(posedge clk);
        #1 d_address = 32'h0000_6000; d_read = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_read === 1'b1) break;
        end
        chk("drop_granted", {255'd0, mem_read}, {255'd0, 1'b1});
        repeat (2) @(posedge clk);
        #1 d_read = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("drop_hold", {255'd0, mem_read}, {255'd0, 1'b1});
        end
        @(posedge clk);
        #1 mem_resp = 1'b1; mem_rdata = pat_5a;
        sb.push_back('{is_d: 1'b1, rdata: pat_5a});
        @(posedge clk);
        #1 mem_resp = 1'b0;
        @(negedge clk);
        chk("drop_idle", {254'd0, mem_read, mem_write}, 256'd0);
        $display("drop: held transaction completed");

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cacheline_arbiter.md
CACHELINE_ARBITER -- requirements
Module: cacheline_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 32, physical address width.
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Ports i_address/d_address  input  ADDR_W  line address from I-cache / D-cache.
REQ-006 Ports i_read/d_read, i_write/d_write  input  1  line read / line write request, held until resp.
REQ-007 Ports i_wdata/d_wdata  input  LINE_W  write line data.
REQ-008 Ports i_rdata/d_rdata  output  LINE_W  read line data returned to requester.
REQ-009 Ports i_resp/d_resp  output  1  one-cycle completion pulse to requester.
REQ-010 Ports mem_address  output  ADDR_W; mem_wdata  output  LINE_W; mem_read, mem_write  output  1  to cacheline adaptor.
REQ-011 Ports mem_rdata  input  LINE_W; mem_resp  input  1  from cacheline adaptor.

Function
REQ-012 The block SHALL implement FSM states IDLE, GRANT_I, GRANT_D.
REQ-013 IDLE: a pending request (read|write) SHALL move to GRANT_I or GRANT_D on the next edge; no request keeps IDLE.
REQ-014 In IDLE both pending SHALL be resolved by the priority policy (REQ-026/027).
REQ-015 In GRANT_x, mem_address/mem_wdata/mem_read/mem_write SHALL combinationally follow the granted requester; ungranted inputs SHALL be ignored.
REQ-016 If a granted requester asserts read and write together, only mem_write SHALL be driven.
REQ-017 In IDLE mem_read and mem_write SHALL be 0; mem_address and mem_wdata are don't-care.
REQ-018 x_resp SHALL equal mem_resp AND state==GRANT_x; the ungranted resp SHALL stay 0.
REQ-019 i_rdata and d_rdata SHALL both carry mem_rdata unmodified; valid only in the resp cycle.
REQ-020 On mem_resp in GRANT_x the FSM SHALL return to IDLE on that edge; arbitration overhead is exactly one IDLE cycle between transactions.
REQ-021 A grant SHALL be held until mem_resp even if the requester drops its request; the transaction completes and resp is still pulsed.
REQ-022 mem_resp in IDLE SHALL be ignored (no resp output, no state change).
REQ-023 A write-back followed by a fill from one cache SHALL be two separate arbitrated transactions.

Reset
REQ-024 reset_n low SHALL force IDLE immediately, without a clock edge, driving mem_read=0, mem_write=0, i_resp=0, d_resp=0.
REQ-025 Reset mid-transaction SHALL abandon it with no resp issued; the round-robin pointer SHALL reset to favour D.

Configuration
REQ-026 With ARB_ROUND_ROBIN_EN defined, on simultaneous requests the block SHALL grant the side not served last; a one-bit last-served register updates on each grant.
REQ-027 Without ARB_ROUND_ROBIN_EN, D SHALL always win simultaneous requests (fixed priority); no pointer register exists.

Verification
REQ-028 d_read=1, d_address=0x0000_1040, adaptor resp after 4 cycles, mem_rdata=0xA5..A5 -> mem_read=1 with mem_address=0x0000_1040 from cycle 1; d_resp pulses once with d_rdata=0xA5..A5; i_resp stays 0.
REQ-029 i_read and d_write asserted same cycle, fixed priority -> D served first (mem_write=1), one IDLE cycle, then I served (mem_read=1); exactly one resp each.
REQ-030 ARB_ROUND_ROBIN_EN, both sides requesting continuously for 4 transactions -> grant order D,I,D,I.
REQ-031 reset_n pulsed low during GRANT_I with mem_read=1 -> mem_read=0 within the same cycle, no i_resp, FSM IDLE after release.
REQ-032 mem_resp=1 injected while IDLE with no requests -> i_resp=d_resp=0, state stays IDLE.
REQ-033 d_read dropped two cycles after grant -> mem_read held until mem_resp, d_resp pulses once, then IDLE.
